// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, debug) and data_memory.
// The arbiter takes the slave view; the requesters and the memory model take the master view.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          c_req;
   logic          c_we;
   logic [1:0]    c_size;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_gnt;
   logic          c_rvalid;
   logic [DW-1:0] c_rdata;

   logic          d_req;
   logic          d_we;
   logic [1:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;

   logic          m_en;
   logic          m_we;
   logic [1:0]    m_size;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   logic          cpu_stall;

   modport slave (
      input  c_req, c_we, c_size, c_addr, c_wdata,
      output c_gnt, c_rvalid, c_rdata,
      input  d_req, d_we, d_size, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output m_en, m_we, m_size, m_addr, m_wdata,
      input  m_rdata,
      output cpu_stall
   );

   modport master (
      output c_req, c_we, c_size, c_addr, c_wdata,
      input  c_gnt, c_rvalid, c_rdata,
      output d_req, d_we, d_size, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_en, m_we, m_size, m_addr, m_wdata,
      output m_rdata,
      input  cpu_stall
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single data-memory port shared by the CPU and the debug/loader
// port; tracks the fixed memory read latency so only one read is ever outstanding.
module dmem_arbiter #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   typedef enum logic {StIdle, StRbusy} state_e;

   state_e        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          rsel_q, rsel_d;   // read owner: 0 cpu, 1 debug
   logic          last_q, last_d;   // most recent grant: 0 cpu, 1 debug
   logic          ret_q, ret_d;     // single-cycle latency return flag

   logic          can_grant;
   logic          ret_valid;
   logic          gnt_c;
   logic          gnt_d;
   logic          sel_we;
   logic [1:0]    sel_size;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         rsel_q  <= 1'b0;
         last_q  <= 1'b1;
         ret_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rsel_q  <= rsel_d;
         last_q  <= last_d;
         ret_q   <= ret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rsel_d  = rsel_q;
      last_d  = last_q;
      ret_d   = 1'b0;
      if (state_q == StRbusy) begin
         if (cnt_q == 2'd0) begin
            state_d = StIdle;
         end else begin
            cnt_d = cnt_q - 2'd1;
         end
      end
      // A read granted in the return cycle overrides the fall back to idle.
      if (gnt_c || gnt_d) begin
         last_d = gnt_d;
         if (!sel_we) begin
            rsel_d = gnt_d;
            if (RD_LAT == 1) begin
               ret_d = 1'b1;
            end else begin
               state_d = StRbusy;
               cnt_d   = 2'(RD_LAT - 1);
            end
         end
      end
   end

   always_comb begin
      can_grant = (state_q == StIdle) || (cnt_q == 2'd0);
      ret_valid = (RD_LAT == 1) ? ret_q : ((state_q == StRbusy) && (cnt_q == 2'd0));
      gnt_c     = 1'b0;
      gnt_d     = 1'b0;
      if (!reset && can_grant) begin
         if (bus.c_req && (!bus.d_req || last_q)) begin
            gnt_c = 1'b1;
         end else if (bus.d_req) begin
            gnt_d = 1'b1;
         end
      end
      sel_we    = 1'b0;
      sel_size  = 2'd0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (gnt_c) begin
         sel_we    = bus.c_we;
         sel_size  = bus.c_size;
         sel_addr  = bus.c_addr;
         sel_wdata = bus.c_wdata;
      end else if (gnt_d) begin
         sel_we    = bus.d_we;
         sel_size  = bus.d_size;
         sel_addr  = bus.d_addr;
         sel_wdata = bus.d_wdata;
      end
   end

   assign bus.c_gnt     = gnt_c;
   assign bus.d_gnt     = gnt_d;
   assign bus.m_en      = gnt_c | gnt_d;
   assign bus.m_we      = sel_we;
   assign bus.m_size    = sel_size;
   assign bus.m_addr    = sel_addr;
   assign bus.m_wdata   = sel_wdata;
   assign bus.c_rvalid  = ret_valid & ~rsel_q & ~reset;
   assign bus.d_rvalid  = ret_valid & rsel_q & ~reset;
   assign bus.c_rdata   = bus.m_rdata;
   assign bus.d_rdata   = bus.m_rdata;
   assign bus.cpu_stall = bus.c_req & ~gnt_c;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: four instances (RD_LAT 1..4) share one stimulus stream and
// each scenario checks the instance whose latency it targets.
module tb_dmem_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          reset;
   logic          c_req, c_we, d_req, d_we;
   logic [1:0]    c_size, d_size;
   logic [AW-1:0] c_addr, d_addr;
   logic [DW-1:0] c_wdata, d_wdata, m_rdata;

   logic          c_gnt_v[4], d_gnt_v[4], c_rvalid_v[4], d_rvalid_v[4];
   logic          m_en_v[4], m_we_v[4], cpu_stall_v[4];
   logic [1:0]    m_size_v[4];
   logic [AW-1:0] m_addr_v[4];
   logic [DW-1:0] m_wdata_v[4], c_rdata_v[4], d_rdata_v[4];

   int n_cmp = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
      assign bus.c_req   = c_req;
      assign bus.c_we    = c_we;
      assign bus.c_size  = c_size;
      assign bus.c_addr  = c_addr;
      assign bus.c_wdata = c_wdata;
      assign bus.d_req   = d_req;
      assign bus.d_we    = d_we;
      assign bus.d_size  = d_size;
      assign bus.d_addr  = d_addr;
      assign bus.d_wdata = d_wdata;
      assign bus.m_rdata = m_rdata;

      dmem_arbiter #(.RD_LAT(g + 1), .AW(AW), .DW(DW)) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );

      assign c_gnt_v[g]     = bus.c_gnt;
      assign d_gnt_v[g]     = bus.d_gnt;
      assign c_rvalid_v[g]  = bus.c_rvalid;
      assign d_rvalid_v[g]  = bus.d_rvalid;
      assign c_rdata_v[g]   = bus.c_rdata;
      assign d_rdata_v[g]   = bus.d_rdata;
      assign m_en_v[g]      = bus.m_en;
      assign m_we_v[g]      = bus.m_we;
      assign m_size_v[g]    = bus.m_size;
      assign m_addr_v[g]    = bus.m_addr;
      assign m_wdata_v[g]   = bus.m_wdata;
      assign cpu_stall_v[g] = bus.cpu_stall;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      c_req = 1'b0; c_we = 1'b0; c_size = 2'd0; c_addr = '0; c_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = '0; d_wdata = '0;
      m_rdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state: requests present but nothing granted, stall follows c_req.
      idle_inputs();
      reset = 1'b1;
      c_req = 1'b1;
      d_req = 1'b1;
      mid();
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("rst_c_gnt[%0d]", i), c_gnt_v[i], 1'b0);
         check_eq($sformatf("rst_d_gnt[%0d]", i), d_gnt_v[i], 1'b0);
         check_eq($sformatf("rst_m_en[%0d]", i), m_en_v[i], 1'b0);
         check_eq($sformatf("rst_stall[%0d]", i), cpu_stall_v[i], 1'b1);
         check_eq($sformatf("rst_c_rvalid[%0d]", i), c_rvalid_v[i], 1'b0);
      end
      next_cycle();
      do_reset();

      // Single CPU write, RD_LAT=2.
      c_req = 1'b1; c_we = 1'b1; c_size = 2'd2; c_addr = 32'h100; c_wdata = 32'hDEADBEEF;
      mid();
      check_eq("wr_c_gnt", c_gnt_v[1], 1'b1);
      check_eq("wr_m_en", m_en_v[1], 1'b1);
      check_eq("wr_m_we", m_we_v[1], 1'b1);
      check_eq("wr_m_size", m_size_v[1], 2'd2);
      check_eq("wr_m_addr", m_addr_v[1], 32'h100);
      check_eq("wr_m_wdata", m_wdata_v[1], 32'hDEADBEEF);
      check_eq("wr_stall", cpu_stall_v[1], 1'b0);
      next_cycle();
      idle_inputs();
      mid();
      check_eq("wr_after_m_en", m_en_v[1], 1'b0);
      check_eq("wr_after_m_addr", m_addr_v[1], 32'h0);
      check_eq("wr_after_c_rvalid", c_rvalid_v[1], 1'b0);
      next_cycle();

      // CPU read, RD_LAT=3: grant in cycle 5, data back in cycle 8, request held throughout.
      do_reset();
      c_req = 1'b1; c_we = 1'b0; c_size = 2'd2; c_addr = 32'h200;
      mid();
      check_eq("rd3_c5_gnt", c_gnt_v[2], 1'b1);
      check_eq("rd3_c5_m_we", m_we_v[2], 1'b0);
      check_eq("rd3_c5_m_addr", m_addr_v[2], 32'h200);
      next_cycle();
      for (int i = 6; i <= 7; i++) begin
         mid();
         check_eq($sformatf("rd3_c%0d_gnt", i), c_gnt_v[2], 1'b0);
         check_eq($sformatf("rd3_c%0d_stall", i), cpu_stall_v[2], 1'b1);
         check_eq($sformatf("rd3_c%0d_rvalid", i), c_rvalid_v[2], 1'b0);
         next_cycle();
      end
      m_rdata = 32'h12345678;
      mid();
      check_eq("rd3_c8_rvalid", c_rvalid_v[2], 1'b1);
      check_eq("rd3_c8_rdata", c_rdata_v[2], 32'h12345678);
      check_eq("rd3_c8_gnt", c_gnt_v[2], 1'b1);
      check_eq("rd3_c8_stall", cpu_stall_v[2], 1'b0);
      next_cycle();
      c_req = 1'b0;
      m_rdata = 32'h0;
      for (int i = 9; i <= 10; i++) begin
         mid();
         check_eq($sformatf("rd3_c%0d_rvalid", i), c_rvalid_v[2], 1'b0);
         next_cycle();
      end
      m_rdata = 32'h0BADF00D;
      mid();
      check_eq("rd3_c11_rvalid", c_rvalid_v[2], 1'b1);
      check_eq("rd3_c11_rdata", c_rdata_v[2], 32'h0BADF00D);
      check_eq("rd3_c11_d_rvalid", d_rvalid_v[2], 1'b0);
      next_cycle();

      // Simultaneous writes after reset: CPU first, then strict alternation.
      do_reset();
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'h1111;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h2222;
      for (int i = 0; i < 4; i++) begin
         mid();
         check_eq($sformatf("rr_c_gnt%0d", i), c_gnt_v[0], (i % 2 == 0) ? 1'b1 : 1'b0);
         check_eq($sformatf("rr_d_gnt%0d", i), d_gnt_v[0], (i % 2 == 1) ? 1'b1 : 1'b0);
         check_eq($sformatf("rr_m_addr%0d", i), m_addr_v[0], (i % 2 == 0) ? 32'h10 : 32'h20);
         check_eq($sformatf("rr_m_wdata%0d", i), m_wdata_v[0],
                  (i % 2 == 0) ? 32'h1111 : 32'h2222);
         check_eq($sformatf("rr_stall%0d", i), cpu_stall_v[0], (i % 2 == 1) ? 1'b1 : 1'b0);
         next_cycle();
      end

      // RD_LAT=1: back-to-back CPU reads, data one cycle behind each grant.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         c_req = 1'b1; c_we = 1'b0; c_size = 2'd2; c_addr = 32'(4 * i);
         m_rdata = 32'hA000_0000 + 32'(i) - 32'd1;
         mid();
         check_eq($sformatf("b2b_gnt%0d", i), c_gnt_v[0], 1'b1);
         check_eq($sformatf("b2b_m_addr%0d", i), m_addr_v[0], 32'(4 * i));
         check_eq($sformatf("b2b_stall%0d", i), cpu_stall_v[0], 1'b0);
         check_eq($sformatf("b2b_rvalid%0d", i), c_rvalid_v[0], (i > 0) ? 1'b1 : 1'b0);
         if (i > 0) begin
            check_eq($sformatf("b2b_rdata%0d", i), c_rdata_v[0], 32'hA000_0000 + 32'(i) - 32'd1);
         end
         next_cycle();
      end
      c_req = 1'b0;
      m_rdata = 32'hA000_0002;
      mid();
      check_eq("b2b_rvalid3", c_rvalid_v[0], 1'b1);
      check_eq("b2b_rdata3", c_rdata_v[0], 32'hA000_0002);
      check_eq("b2b_gnt3", c_gnt_v[0], 1'b0);
      check_eq("b2b_m_en3", m_en_v[0], 1'b0);
      next_cycle();
      mid();
      check_eq("b2b_rvalid4", c_rvalid_v[0], 1'b0);
      next_cycle();

      // RD_LAT=4: debug read in flight, CPU write arrives one cycle later.
      do_reset();
      d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = 32'h300;
      mid();
      check_eq("dbg_d_gnt", d_gnt_v[3], 1'b1);
      check_eq("dbg_m_size", m_size_v[3], 2'd1);
      next_cycle();
      d_req = 1'b0;
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h400; c_wdata = 32'h55AA55AA;
      for (int i = 1; i <= 3; i++) begin
         mid();
         check_eq($sformatf("dbg_t%0d_stall", i), cpu_stall_v[3], 1'b1);
         check_eq($sformatf("dbg_t%0d_c_gnt", i), c_gnt_v[3], 1'b0);
         check_eq($sformatf("dbg_t%0d_d_rvalid", i), d_rvalid_v[3], 1'b0);
         next_cycle();
      end
      m_rdata = 32'hCAFE0001;
      mid();
      check_eq("dbg_t4_d_rvalid", d_rvalid_v[3], 1'b1);
      check_eq("dbg_t4_d_rdata", d_rdata_v[3], 32'hCAFE0001);
      check_eq("dbg_t4_c_rvalid", c_rvalid_v[3], 1'b0);
      check_eq("dbg_t4_c_gnt", c_gnt_v[3], 1'b1);
      check_eq("dbg_t4_m_addr", m_addr_v[3], 32'h400);
      check_eq("dbg_t4_stall", cpu_stall_v[3], 1'b0);
      next_cycle();
      idle_inputs();
      mid();
      check_eq("dbg_t5_d_rvalid", d_rvalid_v[3], 1'b0);
      next_cycle();

      // RD_LAT=3: reset in cycle T+1 discards the read; next request granted at once.
      do_reset();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h500;
      mid();
      check_eq("rst_rd_gnt", c_gnt_v[2], 1'b1);
      next_cycle();
      c_req = 1'b0;
      reset = 1'b1;
      mid();
      check_eq("rst_rd_t1_rvalid", c_rvalid_v[2], 1'b0);
      next_cycle();
      reset = 1'b0;
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h600;
      mid();
      check_eq("rst_rd_t2_gnt", c_gnt_v[2], 1'b1);
      check_eq("rst_rd_t2_stall", cpu_stall_v[2], 1'b0);
      check_eq("rst_rd_t2_rvalid", c_rvalid_v[2], 1'b0);
      next_cycle();
      c_req = 1'b0;
      for (int i = 3; i <= 5; i++) begin
         mid();
         check_eq($sformatf("rst_rd_t%0d_rvalid", i), c_rvalid_v[2], 1'b0);
         check_eq($sformatf("rst_rd_t%0d_d_rvalid", i), d_rvalid_v[2], 1'b0);
         next_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single data-memory port. The CPU load/store path shares the memory with a debug/loader port. The arbiter grants one access at a time with round-robin fairness and tracks the fixed read latency of the memory. It also raises a stall to the CPU while its request is not being served. It sits between the datapath (ALU result / store data / load/store size controls) and `data_memory`.

## Interface
- `RD_LAT`, default 1: memory read latency in cycles, legal range 1..4.
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `c_req`  in  1  CPU access request.
- `c_we`  in  1  CPU write (1) / read (0).
- `c_size`  in  2  access size (0 byte, 1 half, 2 word), passed through.
- `c_addr`  in  AW  CPU address.
- `c_wdata`  in  DW  CPU store data.
- `c_gnt`  out  1  CPU access issued this cycle.
- `c_rvalid`  out  1  CPU read data valid this cycle.
- `c_rdata`  out  DW  CPU read data.
- `d_req`, `d_we`, `d_size`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: debug port, same widths and meanings as the CPU port.
- `m_en`  out  1  memory access strobe.
- `m_we`  out  1  memory write enable.
- `m_size`  out  2  size forwarded to the memory.
- `m_addr`  out  AW  memory address.
- `m_wdata`  out  DW  memory write data.
- `m_rdata`  in  DW  memory read data, valid `RD_LAT` cycles after issue.
- `cpu_stall`  out  1  `c_req & ~c_gnt`.

## Operation
- The FSM has two states: IDLE and RBUSY.
  - Grants are issued only in IDLE, or in the final cycle of RBUSY (the cycle the read data returns).
- A requester holds `req`, `we`, `size`, `addr` and `wdata` stable until it sees `gnt`.
- Arbitration:
  - With one request pending, that requester is granted.
  - With both pending, the requester not granted most recently wins.
  - The last-grant pointer updates on every grant.
- On grant:
  - `m_en` = 1 for that single cycle.
  - `m_we`, `m_size`, `m_addr`, `m_wdata` come combinationally from the granted port.
  - Otherwise all `m_*` outputs are 0.
- Writes complete in the grant cycle. The FSM stays in IDLE, so back-to-back writes are possible every cycle.
- Reads:
  - The grant cycle is T. The FSM records the owner (`rsel`).
  - If `RD_LAT` = 1, no RBUSY is entered and the data returns in T+1, when the next grant is also allowed.
  - If `RD_LAT` > 1, the FSM enters RBUSY with the counter loaded to `RD_LAT`-1, decrements it each cycle, and returns to IDLE after the return cycle.
  - In cycle T+`RD_LAT`, the owner's `rvalid` = 1 for exactly one cycle.
- `c_rdata` and `d_rdata` both equal `m_rdata` at all times; only `rvalid` qualifies them.
- Only one read is outstanding at any time. Any grant issued in the return cycle (a new read, or a write) follows the normal rules above.
- `cpu_stall` is combinational and is 1 whenever the CPU requests without a grant, including during RBUSY.
- Reset:
  - FSM goes to IDLE, counter to 0, `rsel` to 0, last-grant pointer to debug (so the CPU wins the first tie).
  - All `gnt`, `rvalid` and `m_en` are 0.
  - `cpu_stall` = `c_req` during reset.
- Reset mid-read: the pending read is discarded and its `rvalid` never asserts.
- Illegal `size` = 3 is forwarded unchanged; the arbiter does not check it.

## Timing
- Write latency: 0 cycles (grant cycle = issue cycle).
- Read latency: `RD_LAT` cycles from grant to `rvalid`.
- Read throughput: one read every `RD_LAT` cycles. Write throughput: one per cycle.
- A denied requester waits at most one competing access, plus that access's read latency if it is a read.
- Outputs `gnt`, `m_*` and `cpu_stall` are combinational from the requests, FSM state and pointer. `rvalid` is derived from registered state only.

## Test plan
- Single CPU write, `RD_LAT`=2:
  - Stimulus: `c_req`=1, `c_we`=1, `c_addr`=0x100, `c_wdata`=0xDEADBEEF.
  - Response: same cycle `c_gnt`=1, `m_en`=1, `m_we`=1, `m_addr`=0x100, `m_wdata`=0xDEADBEEF, `cpu_stall`=0.
- CPU read, `RD_LAT`=3:
  - Stimulus: grant at cycle 5, memory returns 0x12345678 in cycle 8.
  - Response: `c_rvalid`=1 only in cycle 8 with `c_rdata`=0x12345678; `cpu_stall`=1 in cycles 6-7 if `c_req` is held.
- Simultaneous requests after reset, both writes:
  - Response: CPU granted first, debug the next cycle.
  - With both requests held continuously, grants alternate CPU, debug, CPU, ...
- `RD_LAT`=1, back-to-back CPU reads to 0x0, 0x4, 0x8:
  - Response: grants in 3 consecutive cycles, `c_rvalid` in the 3 following cycles, no stall between.
- Debug read in flight, `RD_LAT`=4, CPU requests one cycle later:
  - Response: CPU stalls 3 cycles and is granted in the cycle `d_rvalid`=1.
- Reset asserted in cycle T+1 of a `RD_LAT`=3 read:
  - Response: no `rvalid` ever appears.
  - In the first cycle after reset is released, a new CPU request is granted immediately.
